// File: rtl/crossbar_switch_sync.sv
// NUM_CH x NUM_CH channel crossbar with a double-buffered selector map.
// Software edits the shadow map; the active map swaps atomically on a frame strobe.

module crossbar_switch_sync_omux #(
  parameter int                  NUM_CH     = 4,
  parameter int                  SEL_WIDTH  = 2,
  parameter int                  IO_WIDTH   = 1,
  parameter int                  OUT_IDX    = 0,
  parameter logic [IO_WIDTH-1:0] IDLE_VALUE = '0
) (
  input  logic [NUM_CH-1:0][SEL_WIDTH-1:0] i_active,
  input  logic [NUM_CH-1:0][IO_WIDTH-1:0]  i_data,
  output logic [IO_WIDTH-1:0]              o_data
);
  // Scan from the top so the lowest-index matching input wins.
  always_comb begin
    o_data = IDLE_VALUE;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_active[i] == SEL_WIDTH'(OUT_IDX)) o_data = i_data[i];
    end
  end
endmodule

module crossbar_switch_sync #(
  parameter int                  NUM_CH     = 4,
  parameter int                  SEL_WIDTH  = 2,
  parameter int                  IO_WIDTH   = 1,
  parameter logic [IO_WIDTH-1:0] IDLE_VALUE = '0
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          cfg_wr_en,
  input  logic [SEL_WIDTH-1:0]          cfg_wr_input,
  input  logic [SEL_WIDTH-1:0]          cfg_wr_sel,
  input  logic                          cfg_commit,
  input  logic                          frame_sync_in,
  input  logic [NUM_CH*IO_WIDTH-1:0]    inputs_flat,
  output logic [NUM_CH*IO_WIDTH-1:0]    outputs_flat,
  output logic [NUM_CH*SEL_WIDTH-1:0]   active_map,
  output logic                          cfg_pending,
  output logic                          cfg_conflict
);
  typedef enum logic {S_IDLE, S_PENDING} state_t;

  state_t                            r_state;
  logic                              r_pending;
  logic                              r_conflict;
  logic [NUM_CH-1:0][SEL_WIDTH-1:0]  r_shadow;
  logic [NUM_CH-1:0][SEL_WIDTH-1:0]  r_active;
  logic [NUM_CH-1:0][IO_WIDTH-1:0]   r_out;

  logic [NUM_CH-1:0][SEL_WIDTH-1:0]  w_ident;
  logic [NUM_CH-1:0][IO_WIDTH-1:0]   w_in;
  logic [NUM_CH-1:0][IO_WIDTH-1:0]   w_nxt;
  logic                              w_conflict;
  logic                              w_wr_ok;

  assign w_in    = inputs_flat;
  assign w_wr_ok = cfg_wr_en && (int'(cfg_wr_input) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ident
    assign w_ident[i] = SEL_WIDTH'(i);
  end

  for (genvar j = 0; j < NUM_CH; j++) begin : g_out
    crossbar_switch_sync_omux #(
      .NUM_CH(NUM_CH), .SEL_WIDTH(SEL_WIDTH), .IO_WIDTH(IO_WIDTH),
      .OUT_IDX(j), .IDLE_VALUE(IDLE_VALUE)
    ) u_mux (
      .i_active (r_active),
      .i_data   (w_in),
      .o_data   (w_nxt[j])
    );
  end

  // Out-of-range entries route nowhere, so they cannot collide.
  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int l = i + 1; l < NUM_CH; l++) begin
        if ((int'(r_shadow[i]) < NUM_CH) && (r_shadow[i] == r_shadow[l]))
          w_conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_shadow  <= w_ident;
      r_active  <= w_ident;
    end else begin
      if (w_wr_ok) r_shadow[cfg_wr_input] <= cfg_wr_sel;
      case (r_state)
        S_IDLE: begin
          if (cfg_commit) begin
            if (frame_sync_in) begin
              r_active <= r_shadow;
            end else begin
              r_state   <= S_PENDING;
              r_pending <= 1'b1;
            end
          end
        end
        S_PENDING: begin
          if (frame_sync_in) begin
            r_active  <= r_shadow;
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_out      <= {NUM_CH{IDLE_VALUE}};
      r_conflict <= 1'b0;
    end else begin
      r_out      <= w_nxt;
      r_conflict <= w_conflict;
    end
  end

  assign outputs_flat = r_out;
  assign active_map   = r_active;
  assign cfg_pending  = r_pending;
  assign cfg_conflict = r_conflict;
endmodule

// File: doc/crossbar_switch_sync.md
Name: crossbar_switch_sync

Overview:
Parametrised NUM_CH x NUM_CH crossbar for routing LED channel data streams between modulator inputs and channel buffers.
- Adds double-buffered selector registers: software writes a shadow map, and the active map changes atomically on a frame boundary.
- Outputs are registered.
- Unmapped outputs drive a defined idle value; they never latch.
- Flags mapping conflicts (two inputs mapped to one output).

Parameters:
NUM_CH, 4, number of input and output channels (2..16)
SEL_WIDTH, 2, selector width; must equal clog2(NUM_CH)
IO_WIDTH, 1, data width per channel
IDLE_VALUE, 0, value driven on any output with no mapped source

Ports:
clk_in  input  1  system clock; all logic on rising edge
rst_n_in  input  1  reset, synchronous, active-low
cfg_wr_en  input  1  write one shadow selector entry this cycle
cfg_wr_input  input  SEL_WIDTH  index of the input whose entry is written
cfg_wr_sel  input  SEL_WIDTH  output index that input is to drive
cfg_commit  input  1  request transfer of shadow map to active map at next frame sync
frame_sync_in  input  1  one-cycle frame boundary strobe
inputs_flat  input  NUM_CH*IO_WIDTH  input channel i at bits [i*IO_WIDTH +: IO_WIDTH]
outputs_flat  output  NUM_CH*IO_WIDTH  registered output channel j, same packing
active_map  output  NUM_CH*SEL_WIDTH  active selector of input i at [i*SEL_WIDTH +: SEL_WIDTH]
cfg_pending  output  1  commit requested, transfer not yet done
cfg_conflict  output  1  registered: shadow map has two or more inputs on one output

Behaviour:
Reset (rst_n_in low at a clock edge):
- Shadow and active maps = identity (entry i = i).
- outputs_flat = IDLE_VALUE on all channels.
- cfg_pending = 0; cfg_conflict = 0; FSM -> IDLE.
- Reset overrides all other inputs in that cycle. A reset during PENDING discards the pending commit.

Shadow writes:
- cfg_wr_en=1 writes shadow[cfg_wr_input] = cfg_wr_sel at the clock edge.
- A write with cfg_wr_input >= NUM_CH is ignored.
- Writes are accepted in any state.

Commit FSM, states IDLE and PENDING:
- IDLE, cfg_commit=1, frame_sync_in=0 -> PENDING; cfg_pending=1 the next cycle.
- IDLE, cfg_commit=1 and frame_sync_in=1 in the same cycle -> active = shadow at that edge; stay IDLE; cfg_pending stays 0.
- PENDING, frame_sync_in=1 -> active = shadow; -> IDLE; cfg_pending=0 the next cycle.
- PENDING, cfg_commit=1 -> no effect (no queuing).
- frame_sync_in in IDLE without a commit -> no effect.
- The transfer copies the shadow value registered before the edge. A cfg_wr_en in the transfer cycle lands in shadow only and takes effect at the next commit.

Routing (from the active map), each cycle:
- outputs[j] <= inputs[i] for the lowest-index i with active[i] == j.
- If no input maps to j, outputs[j] <= IDLE_VALUE.
- An entry >= NUM_CH (possible when NUM_CH is not a power of two) maps nowhere.
- Latency: input to output is 1 cycle.
- A map change appears on the outputs 1 cycle after the active update, i.e. 2 edges after the frame_sync_in edge.

Conflict flag:
- cfg_conflict <= 1 if any two in-range shadow entries are equal, else 0.
- Updated every cycle, so it reflects a write 1 cycle later (2 edges after the write edge).
- The conflict flag is informational only: a commit is never blocked by a conflict.

Test Plan:
- Reset then identity: after release, inputs_flat=4'b1010 (IO_WIDTH=1) -> outputs_flat=4'b1010 one cycle later; cfg_pending=0; active_map=8'b11_10_01_00.
- Atomic update: write map {3,2,0,1} for inputs 0..3, commit, wait 10 cycles -> outputs still identity and cfg_pending=1. Pulse frame_sync_in -> active_map=8'b01_00_10_11. With inputs=4'b0001, outputs=4'b1000 two edges after the sync edge.
- Conflict and idle: shadow {0,0,2,3}, commit with sync in the same cycle -> cfg_conflict=1. Output0 follows input0 (lowest index wins); output1=IDLE_VALUE. Input1 is never visible.
- Same-cycle write at transfer: in PENDING, write input2->1 in the frame_sync_in cycle -> active[2] keeps its old value; after the next commit plus sync, active[2]=1.
- Reset mid-operation: in PENDING with a non-identity shadow, assert rst_n_in=0 for one edge -> cfg_pending=0, both maps identity, outputs=IDLE_VALUE. A later frame_sync_in causes no change.
- Parametrised: NUM_CH=5, SEL_WIDTH=3, IO_WIDTH=8; write entry 4=7 (out of range) -> output4=IDLE_VALUE. Write with cfg_wr_input=6 -> ignored, active_map unchanged after commit.
